// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and bit-timing helpers shared by the UART RX slice.
// Macro UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction
endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer for the asynchronous serial line, idling high.
module uart_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  // Shift the line through two flops; both come out of reset at the idle level.
  always_ff @(posedge clk or negedge rst)
    if (!rst) {r_meta, r_q} <= 2'b11;
    else {r_meta, r_q} <= {i_d, r_meta};
  assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with ready/valid output; define UART_RX_PARITY_EN for even parity.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);
  localparam int CPB  = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF = calc_half_bit(CPB);
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_BITS);
  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rx, r_rx_prev, r_done;
  logic                 w_half, w_full, w_deliver, w_ferr, w_par_ok;
  uart_sync_2ff u_sync (.clk(clk), .rst(rst), .i_d(rx_i), .o_q(w_rx));
  assign w_half = r_cnt == CW'(HALF - 1);
  assign w_full = r_cnt == CW'(CPB - 1);
`ifdef UART_RX_PARITY_EN
  logic r_par_bad, w_perr;
  assign w_perr   = r_state == PARITY && w_full && (w_rx != ^r_shift);
  assign w_par_ok = !r_par_bad;
`else
  assign w_par_ok = 1'b1;
`endif
  assign w_deliver = r_state == STOP && w_full && w_rx && w_par_ok;
  assign w_ferr    = r_state == STOP && w_full && !w_rx;
  // Next-state decode: start on a falling edge, qualify at mid-start, then bit-period sampling.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (r_rx_prev && !w_rx) ? START : IDLE;
      START:   w_next = w_half ? (w_rx ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:    w_next = (w_full && r_bit == BW'(DATA_BITS - 1)) ? PARITY : DATA;
      PARITY:  w_next = w_full ? STOP : PARITY;
`else
      DATA:    w_next = (w_full && r_bit == BW'(DATA_BITS - 1)) ? STOP : DATA;
`endif
      STOP:    w_next = w_full ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // State register and bit-timing counter; the counter restarts on any transition and each bit period.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE || w_next != r_state || w_full) ? '0 : r_cnt + 1'b1;
    end
  // Datapath: edge history, LSB-first shift register, delivery strobe and error pulses.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_rx_prev <= 1'b1;
      r_bit     <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_rx_prev <= w_rx;
      r_bit     <= (r_state != DATA) ? '0 : (w_full ? r_bit + 1'b1 : r_bit);
      r_shift   <= (r_state == DATA && w_full) ? {w_rx, r_shift[DATA_BITS-1:1]} : r_shift;
      r_done    <= w_deliver;
      frame_err <= w_ferr;
    end
`ifdef UART_RX_PARITY_EN
  // Parity verdict is held until the frame ends so the stop bit is still checked.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_par_bad  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      r_par_bad  <= (r_state == IDLE) ? 1'b0 : (r_par_bad | w_perr);
      parity_err <= w_perr;
    end
`endif
  // Output holding register: load when empty or consumed this edge, otherwise drop and flag overrun.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= r_done && rx_valid && !rx_ready;
      if (r_done && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule
